// File: rtl/pht.sv
// Pattern history table: 2-bit saturating counters indexed by {local history, PC index}.
// The fetch stage reads it for direction predictions and execute-stage resolution trains it.
// A clear request starts a sweep that reinitialises every entry to weak-taken.
// A counter tracks how many resolved branches were mispredicted.
//
// Ports
//   clk, rst                                   clock, asynchronous active-low reset
//   pred_req, pred_pc_idx, pred_hist           lookup request
//   pred_valid, pred_taken, pred_ctr           registered lookup result, one cycle later
//   upd_valid, upd_pc_idx, upd_hist            resolution strobe and entry select
//   upd_taken, upd_pred                        actual outcome and predicted direction
//   clear, busy                                sweep request and sweep-in-progress flag
//   mispredict_cnt                             saturating mispredict count
//
// state | meaning
// IDLE  | normal operation: predictions read the table, updates train it
// SWEEP | one entry per cycle is rewritten to 10; updates are dropped
module pht #(
    parameter int s_index = 4,
    parameter int depth   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pred_req,
    input  logic [s_index-1:0] pred_pc_idx,
    input  logic [depth-1:0]   pred_hist,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [1:0]         pred_ctr,
    input  logic               upd_valid,
    input  logic [s_index-1:0] upd_pc_idx,
    input  logic [depth-1:0]   upd_hist,
    input  logic               upd_taken,
    input  logic               upd_pred,
    input  logic               clear,
    output logic               busy,
    output logic [31:0]        mispredict_cnt
);

    localparam int idx_w   = depth + s_index;
    localparam int entries = 1 << idx_w;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_nxt;
    logic [idx_w-1:0] ptr, ptr_nxt;
    logic [1:0]       table_q [entries];

    logic [idx_w-1:0] upd_idx, pred_idx;
    logic [1:0]       upd_old, upd_new, pred_val;
    logic             upd_we, sweep_we;

    assign upd_idx  = {upd_hist, upd_pc_idx};
    assign pred_idx = {pred_hist, pred_pc_idx};
    assign upd_old  = table_q[upd_idx];
    assign busy     = (state == SWEEP);

    always_comb begin
        if (upd_taken) begin
            upd_new = (upd_old == 2'b11) ? 2'b11 : upd_old + 2'd1;
        end else begin
            upd_new = (upd_old == 2'b00) ? 2'b00 : upd_old - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        upd_we    = 1'b0;
        sweep_we  = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end else begin
                    upd_we = upd_valid;
                end
            end
            SWEEP: begin
                sweep_we = 1'b1;
                if (clear) begin
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == '1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < entries; i++) table_q[i] <= 2'b10;
        end else begin
            if (sweep_we) table_q[ptr] <= 2'b10;
            if (upd_we) table_q[upd_idx] <= upd_new;
        end
    end

    // Forward the update committing at this edge so the prediction sees it.
    always_comb begin
        if (state == SWEEP) begin
            pred_val = 2'b10;
        end else if (upd_we && (upd_idx == pred_idx)) begin
            pred_val = upd_new;
        end else begin
            pred_val = table_q[pred_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ctr   <= 2'b00;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_taken <= pred_val[1];
                pred_ctr   <= pred_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_cnt <= '0;
        end else if (state == IDLE && clear) begin
            mispredict_cnt <= '0;
        end else if (upd_we && (upd_pred != upd_taken) && (mispredict_cnt != 32'hFFFF_FFFF)) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pht.sv
module tb_pht;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_req = 1'b0;
    logic [3:0]  pred_pc_idx = '0;
    logic [3:0]  pred_hist = '0;
    logic        pred_valid, pred_taken;
    logic [1:0]  pred_ctr;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_pc_idx = '0;
    logic [3:0]  upd_hist = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_fail = 0;

    pht #(.s_index(4), .depth(4)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc_idx(pred_pc_idx), .pred_hist(pred_hist),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
        .upd_valid(upd_valid), .upd_pc_idx(upd_pc_idx), .upd_hist(upd_hist),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .clear(clear), .busy(busy), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pr;
        logic [3:0] ph, pp;
        logic       uv;
        logic [3:0] uh, up;
        logic       ut, upr;
        logic       ev;
        logic [1:0] ec;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pr, input logic [3:0] ph, input logic [3:0] pp,
                       input logic uv, input logic [3:0] uh, input logic [3:0] up,
                       input logic ut, input logic upr,
                       input logic ev, input logic [1:0] ec, input logic [31:0] ecnt);
        vec_t v;
        v.pr = pr; v.ph = ph; v.pp = pp;
        v.uv = uv; v.uh = uh; v.up = up; v.ut = ut; v.upr = upr;
        v.ev = ev; v.ec = ec; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_req = 0; upd_valid = 0; clear = 0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < 600) begin
            n++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;

        // hist/pc order in add(): pr, ph, pp, uv, uh, up, ut, upr, ev, ec, ecnt
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
        add(0, 0, 0, 1, 3, 5, 0, 1, 0, 2'b10, 1);
        add(0, 0, 0, 1, 3, 5, 0, 0, 0, 2'b10, 1);
        add(0, 0, 0, 1, 3, 5, 0, 0, 0, 2'b10, 1);
        add(1, 3, 5, 0, 0, 0, 0, 0, 1, 2'b00, 1);
        add(0, 0, 0, 1, 3, 5, 1, 0, 0, 2'b00, 2);
        add(0, 0, 0, 1, 3, 5, 1, 0, 0, 2'b00, 3);
        add(0, 0, 0, 1, 3, 5, 1, 1, 0, 2'b00, 3);
        add(0, 0, 0, 1, 3, 5, 1, 1, 0, 2'b00, 3);
        add(1, 3, 5, 0, 0, 0, 0, 0, 1, 2'b11, 3);
        add(1, 2, 1, 1, 2, 1, 1, 1, 1, 2'b11, 3);
        add(1, 2, 1, 1, 2, 1, 1, 0, 1, 2'b11, 4);
        add(1, 2, 1, 1, 2, 1, 0, 1, 1, 2'b10, 5);
        add(1, 3, 5, 1, 2, 1, 0, 0, 1, 2'b11, 5);
        add(1, 2, 1, 0, 0, 0, 0, 0, 1, 2'b01, 5);

        #2;
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_ctr", pred_ctr, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", mispredict_cnt, 0);
        step();
        rst = 1;
        step();

        foreach (vecs[i]) begin
            pred_req = vecs[i].pr; pred_hist = vecs[i].ph; pred_pc_idx = vecs[i].pp;
            upd_valid = vecs[i].uv; upd_hist = vecs[i].uh; upd_pc_idx = vecs[i].up;
            upd_taken = vecs[i].ut; upd_pred = vecs[i].upr;
            step();
            check($sformatf("v%0d_valid", i), pred_valid, vecs[i].ev);
            check($sformatf("v%0d_ctr", i), pred_ctr, vecs[i].ec);
            check($sformatf("v%0d_taken", i), pred_taken, vecs[i].ec[1]);
            check($sformatf("v%0d_cnt", i), mispredict_cnt, vecs[i].ecnt);
        end
        idle_inputs();
        step();

        // Clear with a simultaneous update: clear wins.
        clear = 1; upd_valid = 1; upd_hist = 3; upd_pc_idx = 5; upd_taken = 0; upd_pred = 1;
        step();
        clear = 0;
        check("clr_busy_rise", busy, 1);
        check("clr_cnt_zero", mispredict_cnt, 0);
        // Keep trying to train {3,5} and predict during the sweep.
        upd_taken = 1; upd_pred = 0;
        pred_req = 1; pred_hist = 3; pred_pc_idx = 5;
        measure_busy(n);
        check("sweep_len", n, 256);
        check("sweep_pred_valid", pred_valid, 1);
        check("sweep_pred_ctr", pred_ctr, 2'b10);
        check("sweep_pred_taken", pred_taken, 1);
        idle_inputs();
        step();
        check("sweep_cnt", mispredict_cnt, 0);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            pred_req = 1; pred_hist = i[7:4]; pred_pc_idx = i[3:0];
            step();
            if (pred_ctr !== 2'b10 || pred_valid !== 1'b1) bad++;
        end
        idle_inputs();
        check("table_all_10", bad, 0);

        // Restart the sweep at cycle 100.
        clear = 1;
        step();
        clear = 0;
        for (int i = 0; i < 100; i++) step();
        check("restart_busy_before", busy, 1);
        clear = 1;
        step();
        clear = 0;
        check("restart_busy_after", busy, 1);
        measure_busy(n);
        check("restart_len", n, 256);

        // Train the last entry, then reset mid-sweep.
        upd_valid = 1; upd_hist = 15; upd_pc_idx = 15; upd_taken = 1; upd_pred = 1;
        step();
        upd_valid = 0;
        pred_req = 1; pred_hist = 15; pred_pc_idx = 15;
        step();
        pred_req = 0;
        check("pre_rst_ctr", pred_ctr, 2'b11);
        clear = 1;
        step();
        clear = 0;
        for (int i = 0; i < 50; i++) step();
        rst = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", pred_valid, 0);
        #1;
        rst = 1;
        pred_req = 1; pred_hist = 15; pred_pc_idx = 15;
        step();
        check("postrst_valid", pred_valid, 1);
        check("postrst_ctr", pred_ctr, 2'b10);
        pred_req = 0;
        upd_valid = 1; upd_taken = 1; upd_pred = 0;
        step();
        upd_valid = 0;
        pred_req = 1;
        step();
        pred_req = 0;
        check("postrst_upd_ctr", pred_ctr, 2'b11);
        check("postrst_cnt", mispredict_cnt, 1);
        step();
        check("valid_drops", pred_valid, 0);
        check("ctr_holds", pred_ctr, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
